// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 write-only SPI controller.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic                       rw,
        input logic [ADDR_MSB-ADDR_LSB:0] addr,
        input logic [ADDR_LSB-1:0]        data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_req_fifo.sv
// Two-entry request FIFO that lets the controller accept frames while busy.
module spi_req_fifo
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FRAME_BITS-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [FRAME_BITS-1:0] head
);

    logic [FRAME_BITS-1:0] mem_q [2];
    logic [FRAME_BITS-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_controller.sv
// Mode-0 write-only SPI host: serialises {rw, addr[6:0], data[7:0]} MSB first.
// Define SPI_CTRL_REQ_FIFO_EN to put a 2-entry request FIFO in front of the FSM.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int IDLE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int MAX_AB    = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CD    = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int MAX_PHASE = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

    localparam logic [CNT_W-1:0] LD_DIV   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
    // The IDLE cycle before the next accept is the last ncs-high cycle, so GAP is one shorter.
    localparam logic [CNT_W-1:0] LD_GAP   = (IDLE_GAP > 1) ? CNT_W'(IDLE_GAP - 2) : '0;

    generate
        if (CLK_DIV < 2)  begin : g_bad_clk_div  $error("CLK_DIV must be >= 2");  end
        if (CS_SETUP < 2) begin : g_bad_cs_setup $error("CS_SETUP must be >= 2"); end
        if (CS_HOLD < 2)  begin : g_bad_cs_hold  $error("CS_HOLD must be >= 2");  end
        if (IDLE_GAP < 1) begin : g_bad_idle_gap $error("IDLE_GAP must be >= 1"); end
    endgenerate

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  sclk_q, sclk_d;
    logic                  copi_q, copi_d;
    logic                  ncs_q, ncs_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  start;
    logic [FRAME_BITS-1:0] start_frame;
    logic                  phase_end;
    logic [3:0]            bit_idx_dec;

`ifdef SPI_CTRL_REQ_FIFO_EN
    logic fifo_full, fifo_empty;

    spi_req_fifo u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid && !fifo_full),
        .push_data (pack_frame(req_rw, req_addr, req_data)),
        .pop       (start),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (start_frame)
    );

    assign req_ready = !fifo_full;
    assign start     = (state_q == ST_IDLE) && !fifo_empty;
`else
    assign req_ready   = (state_q == ST_IDLE);
    assign start       = req_valid && req_ready;
    assign start_frame = pack_frame(req_rw, req_addr, req_data);
`endif

    assign phase_end   = (cnt_q == '0);
    assign bit_idx_dec = bit_idx_q - 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ncs_d     = ncs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    frame_d   = start_frame;
                    cnt_d     = LD_SETUP;
                    bit_idx_d = 4'd15;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    copi_d    = start_frame[RW_BIT];
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = LD_DIV;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHIFT_LO: begin
                if (phase_end) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = LD_DIV;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_idx_q == 4'd0) begin
                        state_d = ST_HOLD;
                        cnt_d   = LD_HOLD;
                    end else begin
                        // The next bit goes out on the same edge that drops sclk.
                        state_d   = ST_SHIFT_LO;
                        cnt_d     = LD_DIV;
                        bit_idx_d = bit_idx_dec;
                        copi_d    = frame_q[bit_idx_dec];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    ncs_d  = 1'b1;
                    copi_d = 1'b0;
                    done_d = 1'b1;
                    if (IDLE_GAP > 1) begin
                        state_d = ST_GAP;
                        cnt_d   = LD_GAP;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 4'd0;
            frame_q   <= '0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sclk = sclk_q;
    assign copi = copi_q;
    assign ncs  = ncs_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller with a behavioural SPI register peripheral on the pins.
// Set SPI_CTRL_REQ_FIFO_EN to also exercise the request FIFO.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV      = 4;
    localparam int CS_SETUP     = 4;
    localparam int CS_HOLD      = 4;
    localparam int IDLE_GAP     = 4;
    localparam int NCS_LOW      = CS_SETUP + 2 * CLK_DIV * FRAME_BITS + CS_HOLD;
    localparam int ACC_TO_DONE  = 137;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy, done, sclk, copi, ncs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] sb_q [$];
    int          lat_q [$];
    bit          lat_en = 1'b1;

    // Pin-level observer / peripheral model state
    bit          mon_en = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_ncs  = 1'b1;
    logic        prev_done = 1'b0;
    logic [15:0] shreg = '0;
    int          mon_bits = 0;
    int          low_cnt  = 0;
    int          gap_cnt  = 0;
    bit          gap_chk   = 1'b0;
    bit          gap_armed = 1'b0;
    int          done_cnt  = 0;
    int          short_cnt = 0;
    logic [7:0]  periph  [5];
    logic [7:0]  exp_reg [5];
    logic [7:0]  en_data [4];

    spi_controller #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Receive side: shift on sclk rises, commit full frames on ncs rise like the real peripheral
    always @(negedge clk) begin
        if (mon_en) begin
            if (!ncs) begin
                if (sclk && !prev_sclk) begin
                    shreg = {shreg[14:0], copi};
                    mon_bits++;
                end
                if (prev_ncs) begin
                    if (gap_chk && gap_armed) checkOutput("ncs_gap", gap_cnt, IDLE_GAP);
                    gap_armed = 1'b0;
                end
                low_cnt++;
            end else begin
                if (!prev_ncs) begin
                    if (mon_bits == FRAME_BITS) begin
                        checkOutput("ncs_low_cycles", low_cnt, NCS_LOW);
                        if (sb_q.size() == 0) begin
                            checkOutput("sb_underflow", 1, 0);
                        end else begin
                            checkOutput("frame_bits", shreg, sb_q.pop_front());
                        end
                        if (shreg[15] && shreg[14:8] <= 7'd4) periph[shreg[14:8]] = shreg[7:0];
                        if (gap_chk) gap_armed = 1'b1;
                    end else begin
                        short_cnt++;
                    end
                    mon_bits = 0;
                    low_cnt  = 0;
                    gap_cnt  = 1;
                end else begin
                    gap_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                checkOutput("done_with_ncs_high", ncs, 1);
                checkOutput("done_one_cycle", prev_done, 0);
                if (lat_q.size() > 0) checkOutput("accept_to_done", cyc + 1 - lat_q.pop_front(), ACC_TO_DONE);
            end
            prev_sclk = sclk;
            prev_ncs  = ncs;
            prev_done = done;
        end
    end

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_data  = data;
        while (!req_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            sb_q.push_back({rw, addr, data});
            if (lat_en) lat_q.push_back(cyc + 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) checkOutput("done_timeout", done_cnt, target);
        repeat (IDLE_GAP + 2) @(negedge clk);
    endtask

    task automatic checkRegs();
        for (int i = 0; i < 5; i++) checkOutput($sformatf("periph_reg%0d", i), periph[i], exp_reg[i]);
    endtask

    initial begin
        int         tgt;
        int         accepts;
        int         t;
        logic [7:0] last_data;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        last_data = '0;
        for (int i = 0; i < 5; i++) begin
            periph[i]  = 8'h00;
            exp_reg[i] = 8'h00;
        end
        en_data[0] = 8'h01;
        en_data[1] = 8'h80;
        en_data[2] = 8'hFF;
        en_data[3] = 8'h3C;

        repeat (3) @(negedge clk);
        checkOutput("rst_ncs", ncs, 1);
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_copi", copi, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", req_ready, 1);
        mon_en = 1'b1;
        tgt    = 0;

        $display("[TB] read frame must not write");
        applyStimulus(1'b0, ADDR_EN_OUT_7_0, 8'hFF);
        tgt++;
        waitDone(tgt);
        checkRegs();

        $display("[TB] pwm duty write");
        applyStimulus(1'b1, ADDR_PWM_DUTY, 8'hA5);
        checkOutput("busy_in_frame", busy, 1);
        checkOutput("ready_in_frame", req_ready, 0);
        checkOutput("ncs_in_frame", ncs, 0);
        exp_reg[4] = 8'hA5;
        tgt++;
        waitDone(tgt);
        checkOutput("busy_after_frame", busy, 0);
        checkRegs();

        $display("[TB] enable register writes and out-of-range address");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 7'(i), en_data[i]);
            exp_reg[i] = en_data[i];
            tgt++;
            waitDone(tgt);
        end
        applyStimulus(1'b1, 7'h05, 8'h77);
        tgt++;
        waitDone(tgt);
        checkRegs();

        $display("[TB] valid held high with changing data");
        gap_chk   = 1'b1;
        gap_armed = 1'b0;
        accepts   = 0;
        t         = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = ADDR_PWM_DUTY;
        while (accepts < 2 && t < 1000) begin
            req_data = 8'($urandom);
            if (req_ready) begin
                sb_q.push_back({req_rw, req_addr, req_data});
                lat_q.push_back(cyc + 1);
                last_data = req_data;
                accepts++;
            end
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        checkOutput("held_valid_accepts", accepts, 2);
        tgt += 2;
        waitDone(tgt);
        repeat (20) @(negedge clk);
        checkOutput("held_valid_frames", done_cnt, tgt);
        checkOutput("sb_drained", sb_q.size(), 0);
        exp_reg[4] = last_data;
        checkRegs();
        gap_chk   = 1'b0;
        gap_armed = 1'b0;

        $display("[TB] reset in the middle of a frame");
        applyStimulus(1'b1, ADDR_EN_OUT_7_0, 8'h55);
        t = 0;
        while (mon_bits < 8 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("reached_8_rises", mon_bits, 8);
        rst = 1'b1;
        void'(sb_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        checkOutput("midrst_ncs", ncs, 1);
        checkOutput("midrst_sclk", sclk, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt, tgt);
        checkOutput("midrst_short_frame", short_cnt, 1);
        checkRegs();
        applyStimulus(1'b1, ADDR_EN_OUT_15_8, 8'h5A);
        exp_reg[1] = 8'h5A;
        tgt++;
        waitDone(tgt);
        checkRegs();

`ifdef SPI_CTRL_REQ_FIFO_EN
        $display("[TB] back-to-back requests through the FIFO");
        lat_en    = 1'b0;
        gap_chk   = 1'b1;
        gap_armed = 1'b0;
        accepts   = 0;
        t         = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = ADDR_EN_PWM_7_0;
        while (accepts < 3 && t < 100) begin
            req_data = 8'h10 + 8'(accepts);
            if (req_ready) begin
                sb_q.push_back({req_rw, req_addr, req_data});
                last_data = req_data;
                accepts++;
            end
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        checkOutput("fifo_accepts", accepts, 3);
        checkOutput("fifo_full_ready", req_ready, 0);
        tgt += 3;
        waitDone(tgt);
        checkOutput("fifo_sb_drained", sb_q.size(), 0);
        exp_reg[2] = last_data;
        checkRegs();
        gap_chk = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
